// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI command sequencer / register file.
package spi_ctrl_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } ctrl_state_e;

  // Command byte bit that selects a write frame.
  localparam int          CMD_WR_BIT     = 7;
  // Byte shifted out to the master while it sends the command byte.
  localparam logic [7:0]  DEFAULT_STATUS = 8'hA5;
  // Filler byte shifted out during write frames.
  localparam logic [7:0]  IDLE_FILL      = 8'h00;

  // True when a command byte requests a write frame.
  function automatic logic is_write_cmd(input logic [7:0] cmd);
    return cmd[CMD_WR_BIT];
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-level handshake between the SPI slave shifter and the command sequencer.
interface spi_reg_ctrl_if;
  logic [7:0] rx_byte;   // byte received from the master
  logic       rx_valid;  // one-cycle pulse, rx_byte valid
  logic [7:0] tx_byte;   // next byte to shift out
  logic       tx_load;   // one-cycle preload strobe

  // Shifter side: produces received bytes, consumes preloads.
  modport master (
    output rx_byte,
    output rx_valid,
    input  tx_byte,
    input  tx_load
  );

  // Sequencer side: consumes received bytes, produces preloads.
  modport slave (
    input  rx_byte,
    input  rx_valid,
    output tx_byte,
    output tx_load
  );
endinterface

// File: rtl/spi_reg_ctrl_cs_sync_edge.sv
// Chip-select synchronizer with registered rise/fall pulses.
// The edge register compares the two synchronizer stages, so the fall pulse
// is valid two clocks after the pad changes and the sequencer can preload
// on the third.
module cs_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic cs_i,
  output logic cs_sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic rise_q;
  logic fall_q;

  // Two-flop synchronizer and edge pulses; reset to deselected (cs high).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= cs_i;
      sync2_q <= sync1_q;
      rise_q  <= ~sync2_q &  sync1_q;
      fall_q  <=  sync2_q & ~sync1_q;
    end
  end

  assign cs_sync_o = sync2_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command sequencer and register file behind the SPI slave byte interface.
// First byte of each frame is a command: bit 7 selects write, the low
// address bits give the start register; the address auto-increments and
// wraps modulo NREGS.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | deselected, waiting for a cs falling edge
// ST_CMD   | status byte preloaded, waiting for the command byte
// ST_WRITE | storing each received byte at addr, preloading filler
// ST_READ  | discarding received bytes, preloading reg[addr]
module spi_reg_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int         NREGS       = 16,
  parameter logic [7:0] STATUS_BYTE = DEFAULT_STATUS,
  localparam int        ADDR_W      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  spi_reg_ctrl_if.slave       spi,
  output logic [8*NREGS-1:0]  regs_o,
  output logic                wr_strobe,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic                irq,
  input  logic                irq_clr
);

  ctrl_state_e         state_q;
  logic [7:0]          regs_q [NREGS];
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          tx_byte_q;
  logic                tx_load_q;
  logic                wr_strobe_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic                irq_q;
  logic                wrote_q;

  logic                cs_sync;
  logic                cs_rise;
  logic                cs_fall;
  logic [ADDR_W-1:0]   cmd_addr;
  logic                write_now;

  cs_sync_edge u_cs_sync (
    .clk       (clk),
    .rst       (rst),
    .cs_i      (cs),
    .cs_sync_o (cs_sync),
    .rise_o    (cs_rise),
    .fall_o    (cs_fall)
  );

  assign cmd_addr  = spi.rx_byte[ADDR_W-1:0];
  assign write_now = (state_q == ST_WRITE) && spi.rx_valid;

  // Frame sequencer, register file and interrupt; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      tx_byte_q   <= IDLE_FILL;
      tx_load_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      irq_q       <= 1'b0;
      wrote_q     <= 1'b0;
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= 8'h00;
      end
    end else begin
      tx_load_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      if (irq_clr) begin
        irq_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q   <= ST_CMD;
            tx_byte_q <= STATUS_BYTE;
            tx_load_q <= 1'b1;
          end
        end
        ST_CMD: begin
          if (spi.rx_valid) begin
            tx_load_q <= 1'b1;
            if (is_write_cmd(spi.rx_byte)) begin
              state_q   <= ST_WRITE;
              addr_q    <= cmd_addr;
              tx_byte_q <= IDLE_FILL;
            end else begin
              state_q   <= ST_READ;
              addr_q    <= cmd_addr + ADDR_W'(1);
              tx_byte_q <= regs_q[cmd_addr];
            end
          end
        end
        ST_WRITE: begin
          if (spi.rx_valid) begin
            regs_q[addr_q] <= spi.rx_byte;
            wr_strobe_q    <= 1'b1;
            wr_addr_q      <= addr_q;
            addr_q         <= addr_q + ADDR_W'(1);
            wrote_q        <= 1'b1;
            tx_byte_q      <= IDLE_FILL;
            tx_load_q      <= 1'b1;
          end
        end
        ST_READ: begin
          if (spi.rx_valid) begin
            tx_byte_q <= regs_q[addr_q];
            addr_q    <= addr_q + ADDR_W'(1);
            tx_load_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Frame end overrides the byte handling above: a byte arriving in the
      // same cycle is still stored, but nothing more is preloaded.
      if (state_q != ST_IDLE && cs_rise) begin
        state_q   <= ST_IDLE;
        tx_load_q <= 1'b0;
        wrote_q   <= 1'b0;
        if (wrote_q || write_now) begin
          irq_q <= 1'b1;
        end
      end
    end
  end

  // Flatten the register file for fabric consumers.
  for (genvar k = 0; k < NREGS; k++) begin : g_flat
    assign regs_o[8*k +: 8] = regs_q[k];
  end

  assign spi.tx_byte = tx_byte_q;
  assign spi.tx_load = tx_load_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign irq         = irq_q;

  logic unused_cs_sync;
  assign unused_cs_sync = cs_sync;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: directed frames plus random frames,
// checked against a register-array model of the command protocol.
module tb_spi_reg_ctrl;
  import spi_ctrl_pkg::*;

  localparam int NREGS = 16;
  localparam int AW    = 4;

  typedef logic [7:0] byte_q_t[$];

  logic                clk = 1'b0;
  logic                rst;
  logic                cs;
  logic                irq_clr;
  logic [8*NREGS-1:0]  regs_o;
  logic                wr_strobe;
  logic [AW-1:0]       wr_addr;
  logic                irq;

  spi_reg_ctrl_if bus ();

  spi_reg_ctrl #(.NREGS(NREGS), .STATUS_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .spi       (bus),
    .regs_o    (regs_o),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .irq       (irq),
    .irq_clr   (irq_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] model_regs [NREGS];
  logic [7:0] exp_tx_q [$];
  int         exp_wa_q [$];
  logic [7:0] exp_wd_q [$];
  bit         irq_m;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Preload monitor: every tx_load must match the next expected MISO byte.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.tx_load) begin
        if (exp_tx_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL tx_unexpected: got tx_byte %0h, expected no preload", bus.tx_byte);
        end else begin
          check("tx_byte", bus.tx_byte, exp_tx_q.pop_front());
        end
      end
    end
  end

  // Write monitor: wr_addr on the strobe, register contents one cycle later.
  initial begin
    int a;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (!rst && wr_strobe) begin
        if (exp_wa_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_unexpected: got wr_addr %0d, expected no write", wr_addr);
        end else begin
          a = exp_wa_q.pop_front();
          d = exp_wd_q.pop_front();
          check("wr_addr", wr_addr, a);
          @(negedge clk);
          check("wr_data", regs_o[8*a +: 8], d);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    idle($urandom_range(1, 4));
  endtask

  // One chip-select frame. With end_same the final byte arrives in the same
  // cycle as the synchronized cs rise; clr_same also pulses irq_clr then.
  task automatic frame(input logic [7:0] cmd, input byte_q_t data,
                       input bit end_same, input bit clr_same);
    bit wr;
    int a;
    bit wrote;
    wr    = cmd[7];
    a     = cmd % NREGS;
    wrote = 0;
    exp_tx_q.push_back(8'hA5);
    cs = 1'b0;
    idle(5);
    if (wr) begin
      exp_tx_q.push_back(8'h00);
    end else begin
      exp_tx_q.push_back(model_regs[a]);
      a = (a + 1) % NREGS;
    end
    send_byte(cmd);
    for (int i = 0; i < data.size(); i++) begin
      if (wr) begin
        exp_wa_q.push_back(a);
        exp_wd_q.push_back(data[i]);
        model_regs[a] = data[i];
        wrote = 1;
      end
      if (end_same && i == data.size() - 1) begin
        cs = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.rx_byte  = data[i];
        bus.rx_valid = 1'b1;
        irq_clr      = clr_same;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        irq_clr      = 1'b0;
      end else begin
        exp_tx_q.push_back(wr ? 8'h00 : model_regs[a]);
        send_byte(data[i]);
      end
      a = (a + 1) % NREGS;
    end
    cs = 1'b1;
    idle(4);
    if (wrote) irq_m = 1;
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    @(negedge clk);
    irq_m = 0;
    check("irq_cleared", irq, 0);
  endtask

  initial begin
    byte_q_t d;
    logic [7:0] cmd;
    int n;

    rst = 1'b1; cs = 1'b1; irq_clr = 1'b0;
    bus.rx_byte = 8'h00; bus.rx_valid = 1'b0;
    irq_m = 0;
    for (int k = 0; k < NREGS; k++) model_regs[k] = 8'h00;
    idle(3);
    check("rst_regs", (regs_o == '0), 1);
    check("rst_tx_load", bus.tx_load, 0);
    check("rst_tx_byte", bus.tx_byte, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_irq", irq, 0);
    rst = 1'b0;
    idle(3);

    // Write burst.
    d = '{8'h11, 8'h22};
    frame(8'h83, d, 0, 0);
    check("burst_reg3", regs_o[3*8 +: 8], 8'h11);
    check("burst_reg4", regs_o[4*8 +: 8], 8'h22);
    check("burst_irq", irq, irq_m);
    check("burst_irq_const", irq, 1);
    clear_irq();

    // Read burst: MISO A5, 5A, 6B.
    d = '{8'h5A, 8'h6B};
    frame(8'h85, d, 0, 0);
    clear_irq();
    d = '{8'hFF, 8'hEE};
    frame(8'h05, d, 0, 0);
    check("read_irq", irq, 0);

    // Address wrap 15 -> 0 -> 1.
    d = '{8'hC1, 8'hC2, 8'hC3};
    frame(8'h8F, d, 0, 0);
    check("wrap_reg15", regs_o[15*8 +: 8], 8'hC1);
    check("wrap_reg0", regs_o[0 +: 8], 8'hC2);
    check("wrap_reg1", regs_o[8 +: 8], 8'hC3);
    clear_irq();

    // Command-only write frame.
    d = {};
    frame(8'h80, d, 0, 0);
    check("cmd_only_irq", irq, 0);

    // Final byte coincides with cs rise; irq_clr in the same cycle loses.
    d = '{8'h33, 8'h44};
    frame(8'h84, d, 1, 1);
    check("same_cycle_reg5", regs_o[5*8 +: 8], 8'h44);
    check("same_cycle_irq", irq, 1);
    clear_irq();

    // Reset mid-write after one data byte.
    exp_tx_q.push_back(8'hA5);
    cs = 1'b0;
    idle(5);
    exp_tx_q.push_back(8'h00);
    send_byte(8'h89);
    exp_tx_q.push_back(8'h00);
    exp_wa_q.push_back(9);
    exp_wd_q.push_back(8'h99);
    send_byte(8'h99);
    idle(3);
    rst = 1'b1; cs = 1'b1;
    idle(3);
    for (int k = 0; k < NREGS; k++) model_regs[k] = 8'h00;
    irq_m = 0;
    check("midrst_regs", (regs_o == '0), 1);
    check("midrst_tx_load", bus.tx_load, 0);
    check("midrst_irq", irq, 0);
    rst = 1'b0;
    idle(3);
    d = '{8'h77};
    frame(8'h82, d, 0, 0);
    check("post_rst_reg2", regs_o[2*8 +: 8], 8'h77);
    check("post_rst_irq", irq, 1);
    clear_irq();

    // Random frames.
    for (int t = 0; t < 40; t++) begin
      cmd = 8'($urandom);
      n = $urandom_range(0, 4);
      d = {};
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      frame(cmd, d, ($urandom_range(0, 3) == 0) && n > 0 && cmd[7], 0);
      check("rand_irq", irq, irq_m);
      if (irq_m) clear_irq();
    end

    for (int k = 0; k < NREGS; k++) check("final_reg", regs_o[8*k +: 8], model_regs[k]);
    check("tx_q_drained", exp_tx_q.size(), 0);
    check("wr_q_drained", exp_wa_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
